// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline stage registers.
//   stage_state_t : EMPTY / FULL / SKIDDED occupancy states of a stage
//   OCC_*         : occupancy output encodings
//   bubble_ctrl   : all-zero control pattern loaded on a bubble
//   occ_of()      : maps a stage state to its occupancy encoding
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FULL    = 2'd1,
        SKIDDED = 2'd2
    } stage_state_t;

    localparam logic [1:0] OCC_NONE = 2'd0;
    localparam logic [1:0] OCC_ONE  = 2'd1;
    localparam logic [1:0] OCC_TWO  = 2'd2;

    // Wide enough for any control payload; stages slice the width they need.
    localparam int BUBBLE_CTRL_MAX_W = 1024;
    localparam logic [BUBBLE_CTRL_MAX_W-1:0] bubble_ctrl = '0;

    function automatic logic [1:0] occ_of(stage_state_t s);
        return s == SKIDDED ? OCC_TWO : s == FULL ? OCC_ONE : OCC_NONE;
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// pipe_stage_slot: one pipeline entry (control + data registers).
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   load_i         : capture ctrl_i/data_i at the next edge
//   clear_i        : turn the held control bits into a bubble (data kept)
//   ctrl_i, data_i : payload to capture
//   ctrl_o, data_o : held payload
module pipe_stage_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Load wins over clear; the stage never asks for both at once.
    assign ctrl_d = load_i ? ctrl_i : clear_i ? bubble_ctrl[CTRL_W-1:0] : ctrl_q;
    assign data_d = load_i ? data_i : data_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    assign ctrl_o = ctrl_q;
    assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with valid/ready handshake,
// optional skid slot, flush and a saturating bubble counter.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   flush               : squash every held beat at the next edge
//   in_valid/in_ready   : upstream handshake; in_ctrl/in_data upstream payload
//   out_valid/out_ready : downstream handshake; out_ctrl/out_data payload
//   occupancy           : beats currently held (0..2)
//   bubble_cnt          : cycles downstream was ready but no beat was offered
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128,
    parameter bit SKID   = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    stage_state_t      state_q, state_d;
    logic [CNT_W-1:0]  bubble_q, bubble_d;
    logic              in_fire;
    logic              main_ld, main_clr, skid_ld, skid_clr;
    logic [CTRL_W-1:0] skid_ctrl, main_ctrl_in;
    logic [DATA_W-1:0] skid_data, main_data_in;

    assign out_valid = state_q != EMPTY;

    // With the skid slot, ready is a function of state only, so there is no
    // combinational path from out_ready back to in_ready.
    assign in_ready = !reset && !flush &&
                      (SKID ? state_q != SKIDDED : (!out_valid || out_ready));
    assign in_fire  = in_valid && in_ready;

    assign occupancy  = occ_of(state_q);
    assign bubble_cnt = bubble_q;

    always_comb begin
        state_d  = state_q;
        main_ld  = 1'b0;
        main_clr = 1'b0;
        skid_ld  = 1'b0;
        skid_clr = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = FULL;
                        main_ld = 1'b1;
                    end
                end
                FULL: begin
                    if (in_fire && out_ready) begin
                        main_ld = 1'b1;
                    end else if (in_fire) begin
                        state_d = SKIDDED;
                        skid_ld = 1'b1;
                    end else if (out_ready) begin
                        state_d  = EMPTY;
                        main_clr = 1'b1;
                    end
                end
                SKIDDED: begin
                    if (out_ready) begin
                        state_d  = FULL;
                        main_ld  = 1'b1;
                        skid_clr = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // In SKIDDED in_ready is low, so the main register can only refill from skid.
    assign main_ctrl_in = state_q == SKIDDED ? skid_ctrl : in_ctrl;
    assign main_data_in = state_q == SKIDDED ? skid_data : in_data;

    assign bubble_d = (out_ready && !out_valid && bubble_q != '1) ? bubble_q + CNT_W'(1) : bubble_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= EMPTY;
            bubble_q <= '0;
        end else begin
            state_q  <= state_d;
            bubble_q <= bubble_d;
        end
    end

    pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clock   (clock),
        .reset   (reset),
        .load_i  (main_ld),
        .clear_i (main_clr),
        .ctrl_i  (main_ctrl_in),
        .data_i  (main_data_in),
        .ctrl_o  (out_ctrl),
        .data_o  (out_data)
    );

    if (SKID) begin : g_skid
        pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
            .clock   (clock),
            .reset   (reset),
            .load_i  (skid_ld),
            .clear_i (skid_clr),
            .ctrl_i  (in_ctrl),
            .data_i  (in_data),
            .ctrl_o  (skid_ctrl),
            .data_o  (skid_data)
        );
    end else begin : g_no_skid
        // SKIDDED is unreachable here, so the skid controls are never asserted.
        logic unused_skid;
        assign unused_skid = skid_ld | skid_clr;
        assign skid_ctrl   = '0;
        assign skid_data   = '0;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the pipelined CPU, the next generation of the fixed ID/EX-style latch. It carries a split payload (control bits that must become harmless on a bubble, plus data bits that need not), adds a valid/ready handshake so stalls back-propagate without global enables, and supports an optional 2-entry skid slot that registers `in_ready`. It also provides a synchronous flush for branch/jump squash and a saturating bubble counter for performance analysis.

## Interface
- `CTRL_W`, 8: control payload width (wreg, m2reg, wmem, aluc, ...); forced to zero when the stage holds no valid beat.
- `DATA_W`, 128: data payload width (a, b, imm, pc4, rn, ...); not cleared on a bubble.
- `SKID`, 1: 0 = single register with combinational `in_ready`; 1 = main register plus skid register with registered `in_ready`.
- `CNT_W`, 16: bubble counter width.

- `clock`  in  1  sole clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  squash: discards all held beats at the next edge.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  stage accepts the beat this cycle.
- `in_ctrl`  in  CTRL_W  upstream control payload.
- `in_data`  in  DATA_W  upstream data payload.
- `out_valid`  out  1  beat presented downstream.
- `out_ready`  in  1  downstream accepts the beat this cycle.
- `out_ctrl`  out  CTRL_W  control payload; all-zero whenever `out_valid`=0.
- `out_data`  out  DATA_W  data payload; holds its last loaded value when invalid.
- `occupancy`  out  2  beats held (0..1 for SKID=0, 0..2 for SKID=1).
- `bubble_cnt`  out  CNT_W  count of downstream idle slots, saturating.

## Operation
- Fire rules: `in_fire` = `in_valid & in_ready`; `out_fire` = `out_valid & out_ready`.
- `flush`=1 forces `in_ready`=0 that cycle. At the next edge: state becomes EMPTY, every ctrl register is zeroed, and data registers are unchanged. `flush` overrides every handshake, and `reset` overrides `flush`.
- SKID=0:
  - `in_ready` = `!flush & (!out_valid | out_ready)`.
  - On `in_fire` the main register loads `in_ctrl`/`in_data` and `out_valid`<=1.
  - On `out_fire` without `in_fire`, `out_valid`<=0 and the ctrl register is zeroed.
- SKID=1 states, with `in_ready` = `!flush & (state != SKIDDED)`:
  - EMPTY:
    - `in_fire` -> FULL (main <= in).
  - FULL:
    - `in_fire & out_ready` -> FULL (main <= in).
    - `in_fire & !out_ready` -> SKIDDED (skid <= in).
    - `!in_fire & out_ready` -> EMPTY (main ctrl <= 0).
    - otherwise hold.
  - SKIDDED:
    - `out_ready` -> FULL (main <= skid, skid ctrl <= 0).
    - otherwise hold.
- Outputs always come from the main register. `out_valid` = (state != EMPTY).
- Beat order is strictly preserved. There is no duplication and no loss except on `flush`/`reset`.
- `bubble_cnt` increments when `out_ready & !out_valid & !reset`, and saturates at 2^CNT_W-1. It is cleared only by `reset`; `flush` does not clear it.

## Timing
- Latency: accepted beat appears on `out_*` the cycle after `in_fire`. Throughput: 1 beat/cycle sustained when `out_ready`=1.
- SKID=1: `in_ready` depends only on state and `flush`. There is no combinational `out_ready`->`in_ready` path.
- Reset (edge with `reset`=1): state EMPTY, `out_valid`=0, `out_ctrl`=0, `out_data`=0, skid registers 0, `occupancy`=0, `bubble_cnt`=0. `in_ready`=0 while `reset` is high.
- Reset mid-operation: all held beats are lost. The first beat after reset deasserts may fire in the same cycle.
- Simultaneous `in_fire` and `out_fire` in FULL: the old beat leaves and the new beat loads; `occupancy` stays 1.

## Structure
- Shared package `pipe_pkg`:
  - `stage_state_t` enum {EMPTY, FULL, SKIDDED}.
  - occupancy encodings.
  - a `bubble_ctrl` constant (all-zero) used by every stage register.
- Sub-module `pipe_stage_slot` holds one entry (ctrl+data registers, load enable, ctrl clear). It is instantiated once for main and, when SKID=1, once for skid.

## Test plan
- Reset, then `in_valid`=1 with ctrl=0xA5, data=0x1234 -> `out_valid`=1, `out_ctrl`=0xA5, `out_data`=0x1234 one cycle later; all outputs 0 during reset.
- SKID=1, stream 0x01..0x04 with `out_ready` low for 2 cycles mid-stream -> `occupancy` reaches 2, `in_ready` drops for exactly the stalled cycles, output order is 0x01..0x04 with no gaps once released.
- SKID=0, same stream -> `in_ready` tracks `out_ready` combinationally, `occupancy` ≤1, order preserved.
- `flush` while SKIDDED -> next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0; beat offered during the flush cycle is not accepted.
- `out_ready`=1 with `in_valid`=0 for 5 cycles -> `bubble_cnt`=5. With CNT_W=2 the counter saturates at 3.
- `reset` asserted mid-stream while SKIDDED -> all outputs return to reset values on the next edge, and the stream resumes cleanly after reset deasserts.
